// File: rtl/fifo_share_arb.sv
// fifo_share_arb: two producers share one FIFO enqueue port.
//   Round-robin arbitration decides the grant combinationally in the same cycle
//   as the request. A three-state flush sequencer clears the shared FIFO. While
//   that sequence runs, all grants are blocked.
//
// Ports
//   CLK, RST            clock; asynchronous active-low reset
//   REQ0/D0/ACK0        producer 0 request, data and accept
//   REQ1/D1/ACK1        producer 1 request, data and accept
//   F_D_IN/F_ENQ        enqueue data and strobe to the shared FIFO
//   F_FULL_N            the shared FIFO has room
//   F_CLR               clear strobe to the shared FIFO
//   FLUSH_REQ           start a flush (ignored unless the sequencer is idle)
//   FLUSH_DONE          one-cycle pulse at the end of a flush
//   CNT0/CNT1           free-running per-producer accept counters (they wrap)
module fifo_share_arb #(
  parameter int width = 32,
  parameter int cntw  = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             REQ0,
  input  logic [width-1:0] D0,
  output logic             ACK0,
  input  logic             REQ1,
  input  logic [width-1:0] D1,
  output logic             ACK1,
  output logic [width-1:0] F_D_IN,
  output logic             F_ENQ,
  input  logic             F_FULL_N,
  output logic             F_CLR,
  input  logic             FLUSH_REQ,
  output logic             FLUSH_DONE,
  output logic [cntw-1:0]  CNT0,
  output logic [cntw-1:0]  CNT1
);

  typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_HOLD} state_t;

  state_t          r_state, w_next;
  logic            r_pri;
  logic [cntw-1:0] r_cnt0, r_cnt1;
  logic            w_any, w_win, w_enq;

  // Flush sequencer state register
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (FLUSH_REQ) w_next = S_CLEAR;
      S_CLEAR: w_next = S_HOLD;
      S_HOLD:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Winner: the sole requester, or r_pri on a tie.
  // w_win is meaningless when w_any is 0.
  assign w_any = REQ0 | REQ1;
  assign w_win = (REQ0 & REQ1) ? r_pri : REQ1;

  // RST gates the enqueue path directly, so outputs are quiet during reset
  // even while the inputs are still toggling.
  assign w_enq = RST & w_any & F_FULL_N & (r_state == S_IDLE);

  assign F_ENQ      = w_enq;
  assign ACK0       = w_enq & ~w_win;
  assign ACK1       = w_enq &  w_win;
  assign F_D_IN     = !w_enq ? '0 : (w_win ? D1 : D0);
  assign F_CLR      = (r_state == S_CLEAR);
  assign FLUSH_DONE = (r_state == S_HOLD);
  assign CNT0       = r_cnt0;
  assign CNT1       = r_cnt1;

  // After each accepted word, priority passes to the loser.
  // The counters are not touched by a flush.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_pri  <= 1'b0;
      r_cnt0 <= '0;
      r_cnt1 <= '0;
    end else if (w_enq) begin
      r_pri <= ~w_win;
      if (w_win) r_cnt1 <= r_cnt1 + 1'b1;
      else       r_cnt0 <= r_cnt0 + 1'b1;
    end
  end

endmodule

// File: tb/tb_fifo_share_arb.sv
// Directed bench for fifo_share_arb.
//   u_dut uses the default widths.
//   u_dut2 uses cntw=2, so the counter wrap can be exercised.
module tb_fifo_share_arb;

  logic        CLK = 1'b0;
  logic        RST;
  logic        REQ0, REQ1, F_FULL_N, FLUSH_REQ;
  logic [31:0] D0, D1;
  logic        ACK0, ACK1, F_ENQ, F_CLR, FLUSH_DONE;
  logic [31:0] F_D_IN;
  logic [15:0] CNT0, CNT1;

  logic        b_req0, b_req1, b_full_n, b_flush;
  logic [7:0]  b_d0, b_d1, b_d_in;
  logic        b_ack0, b_ack1, b_enq, b_clr, b_done;
  logic [1:0]  b_cnt0, b_cnt1;

  int n_chk = 0;
  int n_err = 0;

  always #5 CLK = ~CLK;

  fifo_share_arb #(.width(32), .cntw(16)) u_dut (
    .CLK(CLK), .RST(RST),
    .REQ0(REQ0), .D0(D0), .ACK0(ACK0),
    .REQ1(REQ1), .D1(D1), .ACK1(ACK1),
    .F_D_IN(F_D_IN), .F_ENQ(F_ENQ), .F_FULL_N(F_FULL_N), .F_CLR(F_CLR),
    .FLUSH_REQ(FLUSH_REQ), .FLUSH_DONE(FLUSH_DONE), .CNT0(CNT0), .CNT1(CNT1)
  );

  fifo_share_arb #(.width(8), .cntw(2)) u_dut2 (
    .CLK(CLK), .RST(RST),
    .REQ0(b_req0), .D0(b_d0), .ACK0(b_ack0),
    .REQ1(b_req1), .D1(b_d1), .ACK1(b_ack1),
    .F_D_IN(b_d_in), .F_ENQ(b_enq), .F_FULL_N(b_full_n), .F_CLR(b_clr),
    .FLUSH_REQ(b_flush), .FLUSH_DONE(b_done), .CNT0(b_cnt0), .CNT1(b_cnt1)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge CLK);
  endtask

  initial begin
    logic [4:0] exp_clr, exp_done;
    logic [1:0] exp_wrap [5];
    exp_clr  = 5'b10010;
    exp_done = 5'b00100;
    exp_wrap = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

    // Reset is held while every request is active.
    RST = 1'b0; REQ0 = 1'b1; REQ1 = 1'b1; F_FULL_N = 1'b1; FLUSH_REQ = 1'b0;
    D0 = 32'h1111_1111; D1 = 32'h2222_2222;
    b_req0 = 1'b0; b_req1 = 1'b0; b_full_n = 1'b1; b_flush = 1'b0;
    b_d0 = 8'h5A; b_d1 = 8'hC3;
    #3;
    chk("rst_enq",  F_ENQ, 0);
    chk("rst_ack0", ACK0, 0);
    chk("rst_ack1", ACK1, 0);
    chk("rst_din",  F_D_IN, 0);
    chk("rst_clr",  F_CLR, 0);
    chk("rst_done", FLUSH_DONE, 0);
    chk("rst_cnt0", CNT0, 0);
    chk("rst_cnt1", CNT1, 0);

    // Counter wrap on the cntw=2 instance
    cyc(); RST = 1'b1; REQ0 = 1'b0; REQ1 = 1'b0; b_req0 = 1'b1; #1;
    chk("wrap_ack0", b_ack0, 1);
    chk("wrap_din",  b_d_in, 8'h5A);
    for (int i = 0; i < 5; i++) begin
      cyc();
      if (i == 4) b_req0 = 1'b0;
      #1;
      chk($sformatf("wrap_cnt0_%0d", i), b_cnt0, exp_wrap[i]);
    end

    // Tie alternation: expected grants are 0,1,0,1
    for (int i = 0; i < 4; i++) begin
      cyc(); REQ0 = 1'b1; REQ1 = 1'b1; #1;
      chk($sformatf("alt_ack0_%0d", i), ACK0, (i % 2 == 0) ? 1 : 0);
      chk($sformatf("alt_ack1_%0d", i), ACK1, (i % 2 == 1) ? 1 : 0);
      chk($sformatf("alt_din_%0d", i), F_D_IN, (i % 2 == 0) ? 32'h1111_1111 : 32'h2222_2222);
    end

    // Full stall with REQ1 only, then release
    cyc(); REQ0 = 1'b0; REQ1 = 1'b1; D1 = 32'hA5; F_FULL_N = 1'b0; #1;
    chk("alt_cnt0", CNT0, 2);
    chk("alt_cnt1", CNT1, 2);
    chk("full_enq_0", F_ENQ, 0);
    chk("full_din_0", F_D_IN, 0);
    for (int i = 1; i < 3; i++) begin
      cyc(); #1;
      chk($sformatf("full_enq_%0d", i), F_ENQ, 0);
      chk($sformatf("full_ack1_%0d", i), ACK1, 0);
    end
    cyc(); F_FULL_N = 1'b1; #1;
    chk("rel_enq",  F_ENQ, 1);
    chk("rel_ack1", ACK1, 1);
    chk("rel_din",  F_D_IN, 32'hA5);
    cyc(); REQ0 = 1'b1; #1;
    chk("pri0_ack0", ACK0, 1);
    chk("pri0_ack1", ACK1, 0);

    // Single-cycle flush with REQ0 active
    cyc(); REQ1 = 1'b0; D0 = 32'h33; FLUSH_REQ = 1'b1; #1;
    chk("fl_cnt0", CNT0, 3);
    chk("fl_cnt1", CNT1, 3);
    chk("fl_a_ack0", ACK0, 1);
    chk("fl_a_din",  F_D_IN, 32'h33);
    chk("fl_a_clr",  F_CLR, 0);
    cyc(); FLUSH_REQ = 1'b0; #1;
    chk("fl_b_clr",  F_CLR, 1);
    chk("fl_b_ack0", ACK0, 0);
    chk("fl_b_enq",  F_ENQ, 0);
    chk("fl_b_din",  F_D_IN, 0);
    cyc(); #1;
    chk("fl_c_done", FLUSH_DONE, 1);
    chk("fl_c_clr",  F_CLR, 0);
    chk("fl_c_ack0", ACK0, 0);
    cyc(); #1;
    chk("fl_d_ack0", ACK0, 1);
    chk("fl_d_done", FLUSH_DONE, 0);

    // FLUSH_REQ held for five cycles: a request made outside IDLE is dropped
    for (int i = 0; i < 5; i++) begin
      cyc(); REQ0 = 1'b0; FLUSH_REQ = 1'b1; #1;
      if (i == 0) chk("hold_cnt0", CNT0, 5);
      chk($sformatf("hold_clr_%0d", i + 1), F_CLR, exp_clr[i]);
      chk($sformatf("hold_done_%0d", i + 1), FLUSH_DONE, exp_done[i]);
    end
    cyc(); FLUSH_REQ = 1'b0; #1;
    chk("hold_done_6", FLUSH_DONE, 1);
    chk("hold_clr_6",  F_CLR, 0);

    // Reset during CLEAR aborts the flush
    cyc(); FLUSH_REQ = 1'b1; #1;
    chk("ab_idle_clr", F_CLR, 0);
    cyc(); FLUSH_REQ = 1'b0; #1;
    chk("ab_clr", F_CLR, 1);
    #2 RST = 1'b0; #1;
    chk("ab_clr_drop", F_CLR, 0);
    chk("ab_done",     FLUSH_DONE, 0);
    chk("ab_cnt0",     CNT0, 0);
    chk("ab_cnt1",     CNT1, 0);
    for (int i = 0; i < 2; i++) begin
      cyc(); REQ0 = 1'b1; REQ1 = 1'b1; #1;
      chk($sformatf("ab_rst_done_%0d", i), FLUSH_DONE, 0);
      chk($sformatf("ab_rst_enq_%0d", i), F_ENQ, 0);
    end

    // First tie after reset goes to producer 0
    cyc(); RST = 1'b1; D0 = 32'h44; #1;
    chk("post_ack0", ACK0, 1);
    chk("post_ack1", ACK1, 0);
    chk("post_din",  F_D_IN, 32'h44);
    chk("post_done", FLUSH_DONE, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/fifo_share_arb.md
FIFO_SHARE_ARB -- requirements
Module: fifo_share_arb

Interface
REQ-001 Parameter: width, default 32, data width of both producer ports and the shared FIFO enqueue data.
REQ-002 Parameter: cntw, default 16, width of each per-producer accept counter.
REQ-003 CLK  input  1  single clock; all state updates on the rising edge.
REQ-004 RST  input  1  reset, asynchronous assertion, active-low (0 = reset).
REQ-005 REQ0  input  1  producer 0 has valid data.
REQ-006 D0  input  width  producer 0 data.
REQ-007 ACK0  output  1  producer 0 data accepted this cycle.
REQ-008 REQ1  input  1  producer 1 has valid data.
REQ-009 D1  input  width  producer 1 data.
REQ-010 ACK1  output  1  producer 1 data accepted this cycle.
REQ-011 F_D_IN  output  width  data to the shared FIFO enqueue port.
REQ-012 F_ENQ  output  1  enqueue strobe to the shared FIFO.
REQ-013 F_FULL_N  input  1  shared FIFO not full.
REQ-014 F_CLR  output  1  clear strobe to the shared FIFO.
REQ-015 FLUSH_REQ  input  1  request to clear the shared FIFO.
REQ-016 FLUSH_DONE  output  1  one-cycle pulse when the flush sequence completes.
REQ-017 CNT0, CNT1  output  cntw  count of accepted words per producer.

Function
REQ-018 Flush FSM states IDLE, CLEAR, HOLD; IDLE->CLEAR when FLUSH_REQ=1 in IDLE; CLEAR->HOLD and HOLD->IDLE unconditionally after one cycle.
REQ-019 FLUSH_REQ outside IDLE is ignored; no queuing of a second flush.
REQ-020 F_CLR = 1 exactly in CLEAR; FLUSH_DONE = 1 exactly in HOLD.
REQ-021 Grants are issued only in IDLE; in CLEAR and HOLD: F_ENQ=0, ACK0=0, ACK1=0.
REQ-022 Priority register pri (0 or 1) selects the favoured producer when both REQ0 and REQ1 are high.
REQ-023 Winner is the sole requester, or pri when both request; no winner when neither requests.
REQ-024 F_ENQ = (winner exists) AND F_FULL_N AND (state = IDLE), combinational, zero-cycle latency.
REQ-025 ACKn = F_ENQ AND (winner = n); at most one ACK per cycle.
REQ-026 F_D_IN = winner's data when F_ENQ=1; F_D_IN = 0 when F_ENQ=0.
REQ-027 On a cycle with F_ENQ=1, pri updates to the loser index (the non-winning producer); otherwise pri holds.
REQ-028 With both requesting continuously and F_FULL_N=1, grants alternate every cycle; no producer waits more than one accepted word of the other.
REQ-029 F_FULL_N=0: no enqueue, no ACK, pri unchanged; producers keep REQ and data stable until ACK.
REQ-030 CNTn increments by 1 on each cycle with ACKn=1 and wraps from 2^cntw-1 to 0.
REQ-031 Counters are not cleared by a flush.
REQ-032 A FLUSH_REQ cycle in IDLE still permits that cycle's enqueue; blocking starts the next cycle.

Reset
REQ-033 While RST=0, asynchronously: state=IDLE, pri=0, CNT0=CNT1=0, F_CLR=0, FLUSH_DONE=0.
REQ-034 While RST=0, F_ENQ, ACK0 and ACK1 are forced to 0 regardless of inputs.
REQ-035 RST asserted mid-flush aborts the sequence immediately; no FLUSH_DONE pulse is produced for the aborted flush.
REQ-036 First cycle after RST=1: producer 0 wins any tie.

Verification
REQ-037 Reset, REQ0=REQ1=1, F_FULL_N=1 for 4 cycles -> ACK sequence 0,1,0,1; CNT0=2, CNT1=2; F_D_IN tracks D0/D1 alternately.
REQ-038 REQ1 only, D1=0xA5, F_FULL_N=0 for 3 cycles then 1 -> F_ENQ=0 for 3 cycles, then F_ENQ=1, ACK1=1, F_D_IN=0xA5; pri then 0.
REQ-039 FLUSH_REQ=1 for 1 cycle with REQ0=1 -> that cycle ACK0=1; next cycle F_CLR=1, ACK0=0; following cycle FLUSH_DONE=1, ACK0=0; then ACK0 resumes.
REQ-040 FLUSH_REQ held high 5 cycles -> F_CLR pulses at cycles 2 and 5 (IDLE, CLEAR, HOLD, IDLE, CLEAR), FLUSH_DONE at cycles 3 and 6.
REQ-041 cntw=2, REQ0=1 for 5 accepted words -> CNT0 = 1,2,3,0,1.
REQ-042 RST=0 asserted while in CLEAR -> F_CLR drops without a clock edge, FLUSH_DONE never pulses, counters read 0.
